// File: rtl/display_scan_7seg.sv
// Four-digit common-anode 7-segment scanner with a shadow register committed once per frame.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module display_scan_7seg #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  AC,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_val_q, shadow_val_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [15:0]      disp_val_q, disp_val_d;
  logic [3:0]       disp_dp_q, disp_dp_d;
  logic             pending_q, pending_d;
  logic [3:0]       ac_q, ac_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end;
  logic             commit;
  logic [3:0]       nibble;
  logic             blank_digit;

  function automatic logic [6:0] decode_hex(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    blank_digit = 1'b0;
    case (idx_q)
      2'd3:    blank_digit = (disp_val_q[15:12] == 4'h0);
      2'd2:    blank_digit = (disp_val_q[15:8] == 8'h00);
      2'd1:    blank_digit = (disp_val_q[15:4] == 12'h000);
      default: blank_digit = 1'b0;
    endcase
  end
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    commit       = slot_end && (idx_q == 2'd3);
    nibble       = disp_val_q[{idx_q, 2'b00} +: 4];

    cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d        = slot_end ? idx_q + 2'd1 : idx_q;

    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;

    // Commit reads the pre-edge shadow, so a load on the commit edge waits a frame.
    if (commit && pending_q) begin
      disp_val_d = shadow_val_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    frame_done_d = commit;

    // The last cycle of each slot is followed by one dark cycle to avoid ghosting.
    if (slot_end) begin
      ac_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      ac_d  = ~(4'b0001 << idx_q);
      seg_d = blank_digit ? 7'h7F : decode_hex(nibble);
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      disp_val_q   <= 16'h0000;
      disp_dp_q    <= 4'h0;
      pending_q    <= 1'b0;
      ac_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      ac_q         <= ac_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign AC         = ac_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Self-checking bench for display_scan_7seg: vector table, directed corner sequences
// and randomized traffic against a frame-position reference model.
module tb_display_scan_7seg;

  localparam int P     = 4;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;

  logic [3:0]  ac;
  logic [6:0]  seg;
  logic        dp;
  logic        fd;
  logic [3:0]  ac2;
  logic [6:0]  seg2;
  logic        dp2;
  logic        fd2;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_7seg #(.PRESCALE(P), .CNT_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .AC(ac), .SEG(seg), .DP(dp), .frame_done(fd)
  );

  // Minimum legal prescale: one lit cycle and one guard cycle per digit.
  display_scan_7seg #(.PRESCALE(2), .CNT_W(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .AC(ac2), .SEG(seg2), .DP(dp2), .frame_done(fd2)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_rom [16];

  // Reference model: position is the number of edges since reset, everything else is arithmetic on it.
  int          m_n;
  logic [15:0] m_sv, m_dv;
  logic [3:0]  m_sd, m_dd;
  logic        m_pend;
  logic [3:0]  e_ac;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;

  typedef struct packed {
    logic [15:0]     val;
    logic [3:0]      dpv;
    logic [3:0][6:0] seg_e;
    logic [3:0]      dpn_e;
  } vec_t;

  vec_t vecs [6];

  task automatic modelEdge(input logic rn, input logic ld, input logic [15:0] v, input logic [3:0] d);
    int phase;
    int digit;
    if (!rn) begin
      m_n = 0; m_sv = '0; m_sd = '0; m_dv = '0; m_dd = '0; m_pend = 1'b0;
      e_ac = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      phase = m_n % P;
      digit = (m_n / P) % 4;
      if (phase == P - 1) begin
        e_ac = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_ac = 4'hF;
        e_ac[digit] = 1'b0;
        e_seg = seg_rom[m_dv[4*digit +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
        if (digit != 0 && (m_dv >> (4 * digit)) == 16'h0000) e_seg = 7'h7F;
`endif
        e_dp = ~m_dd[digit];
      end
      e_fd = ((m_n % FRAME) == FRAME - 1);
      if (e_fd && m_pend) begin
        m_dv = m_sv; m_dd = m_sd; m_pend = 1'b0;
      end
      if (ld) begin
        m_sv = v; m_sd = d; m_pend = 1'b1;
      end
      m_n++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got AC=%b SEG=%b DP=%b fd=%b, required AC=%b SEG=%b DP=%b fd=%b",
               name, act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare off the edge.
  task automatic applyStimulus(input logic rn, input logic ld, input logic [15:0] v, input logic [3:0] d);
    rst_n = rn; load = ld; value = v; dp_in = d;
    @(posedge clk);
    modelEdge(rn, ld, v, d);
    #1;
    checkOutput("model", {ac, seg, dp, fd}, {e_ac, e_seg, e_dp, e_fd});
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
  endtask

  task automatic alignFrame();
    while ((m_n % FRAME) != 0) idle();
  endtask

  // Checks the first lit cycle of each digit of the frame that starts now.
  task automatic checkFrameDigits(input string name, input vec_t vc);
    logic [3:0] a;
    for (int k = 0; k < 4; k++) begin
      idle();
      a = 4'hF;
      a[k] = 1'b0;
      checkOutput($sformatf("%s digit%0d", name, k), {ac, seg, dp, fd}, {a, vc.seg_e[k], vc.dpn_e[k], 1'b0});
      for (int j = 0; j < P - 1; j++) idle();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  a;
    logic        lit;
    logic [15:0] rv;
    logic        rn, ld;

    seg_rom = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    vecs[0] = '{16'h1A8F, 4'b0010, {7'b1001111, 7'b0001000, 7'b0000000, 7'b0111000}, 4'b1101};
    vecs[1] = '{16'hC3E7, 4'b1001, {7'b0110001, 7'b0000110, 7'b0110000, 7'b0001111}, 4'b0110};
    vecs[2] = '{16'h9D2B, 4'b0100, {7'b0000100, 7'b1000010, 7'b0010010, 7'b1100000}, 4'b1011};
    vecs[3] = '{16'h4605, 4'b0000, {7'b1001100, 7'b0100000, 7'b0000001, 7'b0100100}, 4'b1111};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[4] = '{16'h0050, 4'b0000, {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}, 4'b1111};
    vecs[5] = '{16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1111};
`else
    vecs[4] = '{16'h0050, 4'b0000, {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b1111};
    vecs[5] = '{16'h0000, 4'b0000, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};
`endif

    // Reset state, then one free-running frame with no load.
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0);
    checkOutput("reset", {ac, seg, dp, fd}, {4'hF, 7'h7F, 1'b1, 1'b0});
    checkOutput("reset p2", {ac2, seg2, dp2, fd2}, {4'hF, 7'h7F, 1'b1, 1'b0});
    for (int i = 0; i < FRAME; i++) begin
      idle();
      lit = ((i % P) != P - 1);
      a = 4'hF;
      if (lit) a[i / P] = 1'b0;
      checkOutput($sformatf("scan c%0d", i), {ac, seg, dp, fd},
                  {a, lit ? 7'b0000001 : 7'h7F, 1'b1, (i == FRAME - 1)});
      if (i < 8) begin
        a = 4'hF;
        if ((i % 2) == 0) a[i / 2] = 1'b0;
        checkOutput($sformatf("scan p2 c%0d", i), {ac2, seg2, dp2, fd2},
                    {a, ((i % 2) == 0) ? 7'b0000001 : 7'h7F, 1'b1, (i == 7)});
      end
    end

    // Vector table: load mid-frame, display must only change at the next frame.
    for (int v = 0; v < 6; v++) begin
      alignFrame();
      for (int j = 0; j < 6; j++) idle();
      applyStimulus(1'b1, 1'b1, vecs[v].val, vecs[v].dpv);
      alignFrame();
      checkFrameDigits($sformatf("vec%0d", v), vecs[v]);
    end

    // Two loads in one frame: the last one wins.
    alignFrame();
    idle(); idle();
    applyStimulus(1'b1, 1'b1, 16'h1111, 4'h0);
    idle(); idle(); idle();
    applyStimulus(1'b1, 1'b1, 16'h2222, 4'h0);
    alignFrame();
    idle();
    checkOutput("last load wins", {ac, seg, dp, fd}, {4'b1110, 7'b0010010, 1'b1, 1'b0});

    // Load on the commit edge: old shadow commits now, new value one frame later.
    alignFrame();
    idle();
    applyStimulus(1'b1, 1'b1, 16'h7777, 4'h0);
    while ((m_n % FRAME) != FRAME - 1) idle();
    applyStimulus(1'b1, 1'b1, 16'h3333, 4'h0);
    checkOutput("commit edge fd", {ac, seg, dp, fd}, {4'hF, 7'h7F, 1'b1, 1'b1});
    idle();
    checkOutput("commit edge old", {ac, seg, dp, fd}, {4'b1110, 7'b0001111, 1'b1, 1'b0});
    alignFrame();
    idle();
    checkOutput("commit edge new", {ac, seg, dp, fd}, {4'b1110, 7'b0000110, 1'b1, 1'b0});

    // Reset mid-frame with a pending load: the pending value is discarded.
    alignFrame();
    idle(); idle();
    applyStimulus(1'b1, 1'b1, 16'h8888, 4'hF);
    idle(); idle();
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0);
    checkOutput("mid reset", {ac, seg, dp, fd}, {4'hF, 7'h7F, 1'b1, 1'b0});
    idle();
    checkOutput("after reset", {ac, seg, dp, fd}, {4'b1110, 7'b0000001, 1'b1, 1'b0});
    for (int j = 0; j < 2 * FRAME; j++) idle();
    alignFrame();
    idle();
    checkOutput("pending dropped", {ac, seg, dp, fd}, {4'b1110, 7'b0000001, 1'b1, 1'b0});

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 1200; i++) begin
      rn = ($urandom_range(0, 149) != 0);
      ld = ($urandom_range(0, 5) == 0);
      rv = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      applyStimulus(rn, ld, rv, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
